// File: rtl/keypad_event_ctrl_if.sv
// Event handshake between the keypad event controller (master) and its consumer (slave).
// The head of the event FIFO is presented with valid/ready flow control.
interface keypad_event_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_type;
    logic [3:0] ev_code;

    modport master (output ev_valid, ev_type, ev_code, input ev_ready);
    modport slave  (input ev_valid, ev_type, ev_code, output ev_ready);
endinterface

// File: rtl/keypad_event_ctrl.sv
// Turns per-column keypad scanner samples into PRESS / REPEAT / RELEASE events,
// confirming keys over whole scan frames and queueing events in a small FIFO.
module keypad_event_ctrl #(
    parameter int CONFIRM_FRAMES = 2,
    parameter int REPEAT_DELAY   = 16,
    parameter int REPEAT_RATE    = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   col_idx,
    input  logic                         key_hit,
    input  logic [3:0]                   key_code,
    input  logic                         repeat_en,
    input  logic                         clr_ovf,
    keypad_event_ctrl_if.master          ev,
    output logic                         held,
    output logic [3:0]                   held_code,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_REPEAT  = 2'd3;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    localparam logic [7:0] CONFIRM_CNT = 8'(CONFIRM_FRAMES);
    localparam logic [7:0] DELAY_CNT   = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_CNT    = 8'(REPEAT_RATE);
    localparam logic [AW:0] DEPTH_CNT  = (AW + 1)'(FIFO_DEPTH);

    // ---------------- frame boundary and accumulator ----------------
    logic [1:0] prev_col;
    logic       frame_end;
    logic       seen;
    logic       multi;
    logic [3:0] acc_code;

    assign frame_end = (prev_col == 2'd3) && (col_idx == 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_col <= 2'd3;
            seen     <= 1'b0;
            multi    <= 1'b0;
            acc_code <= 4'd0;
        end else begin
            prev_col <= col_idx;
            if (frame_end) begin
                // The boundary cycle's sample already belongs to the new frame.
                seen     <= key_hit;
                multi    <= 1'b0;
                acc_code <= key_code;
            end else if (key_hit) begin
                if (!seen) begin
                    seen     <= 1'b1;
                    acc_code <= key_code;
                end else if (key_code != acc_code) begin
                    multi <= 1'b1;
                end
            end
        end
    end

    logic res_none;
    logic res_single;

    assign res_none   = !seen;
    assign res_single = seen && !multi;

    // ---------------- key state machine ----------------
    logic [1:0] state, state_d;
    logic [3:0] cand, cand_d;
    logic [7:0] cnt, cnt_d, cnt_inc, rep_thr;
    logic       push;
    logic [1:0] push_type;

    assign cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;
    assign rep_thr = (state == S_REPEAT) ? RATE_CNT : DELAY_CNT;

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        cand_d    = cand;
        cnt_d     = cnt;
        push      = 1'b0;
        push_type = EV_PRESS;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (res_single) begin
                        cand_d  = acc_code;
                        cnt_d   = 8'd1;
                        state_d = S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (res_none) begin
                        state_d = S_IDLE;
                    end else if (res_single && acc_code == cand) begin
                        if (cnt_inc == CONFIRM_CNT) begin
                            push    = 1'b1;
                            cnt_d   = 8'd0;
                            state_d = S_HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (res_single) begin
                        cand_d = acc_code;
                        cnt_d  = 8'd1;
                    end
                end
                S_HELD, S_REPEAT: begin
                    if (res_none) begin
                        push      = 1'b1;
                        push_type = EV_RELEASE;
                        state_d   = S_IDLE;
                    end else if (res_single && acc_code != cand) begin
                        push      = 1'b1;
                        push_type = EV_RELEASE;
                        cand_d    = acc_code;
                        cnt_d     = 8'd1;
                        state_d   = S_CONFIRM;
                    end else if (res_single) begin
                        if (state == S_REPEAT && !repeat_en) begin
                            cnt_d   = 8'd0;
                            state_d = S_HELD;
                        end else if (repeat_en && cnt_inc == rep_thr) begin
                            push      = 1'b1;
                            push_type = EV_REPEAT;
                            cnt_d     = 8'd0;
                            state_d   = S_REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cand  <= 4'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_d;
            cand  <= cand_d;
            cnt   <= cnt_d;
        end
    end

    assign held      = (state == S_HELD) || (state == S_REPEAT);
    assign held_code = cand;

    // ---------------- event FIFO ----------------
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop;
    logic          push_ok;

    assign pop     = ev.ev_valid && ev.ev_ready;
    assign push_ok = push && ((fifo_count < DEPTH_CNT) || pop);

    // NOTE: storage is not reset; reset empties the FIFO through its pointers
    // and count, and the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {push_type, cand};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            // A drop in the same cycle as a clear must stay visible.
            if (push && !push_ok) overflow <= 1'b1;
            else if (clr_ovf)     overflow <= 1'b0;
        end
    end

    assign ev.ev_valid = (fifo_count != '0);
    assign ev.ev_type  = ev.ev_valid ? mem[rd_ptr][5:4] : 2'b00;
    assign ev.ev_code  = ev.ev_valid ? mem[rd_ptr][3:0] : 4'd0;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed self-checking bench for keypad_event_ctrl with default parameters.
// Frames are driven as columns 1..3 followed by the column-0 boundary cycle.
module tb_keypad_event_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] col_idx;
    logic       key_hit;
    logic [3:0] key_code;
    logic       repeat_en;
    logic       clr_ovf;
    logic       held;
    logic [3:0] held_code;
    logic [2:0] fifo_count;
    logic       overflow;

    keypad_event_ctrl_if ev_if ();

    keypad_event_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .col_idx    (col_idx),
        .key_hit    (key_hit),
        .key_code   (key_code),
        .repeat_en  (repeat_en),
        .clr_ovf    (clr_ovf),
        .ev         (ev_if),
        .held       (held),
        .held_code  (held_code),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [5:0] evq[$];

    // Records every accepted event; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!reset && ev_if.ev_valid && ev_if.ev_ready)
            evq.push_back({ev_if.ev_type, ev_if.ev_code});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ev_at(input int i);
        if (i < evq.size()) return evq[i];
        return 6'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = no key, 1 = single key c1, 2 = two keys c1 and c2 in one frame.
    task automatic frame_body(input int kind, input logic [3:0] c1, input logic [3:0] c2);
        col_idx = 2'd1; key_hit = (kind != 0); key_code = c1;                    tick();
        col_idx = 2'd2; key_hit = (kind != 0); key_code = (kind == 2) ? c2 : c1; tick();
        col_idx = 2'd3; key_hit = 1'b0;        key_code = 4'd0;                  tick();
    endtask

    task automatic frame_close();
        col_idx = 2'd0; key_hit = 1'b0; key_code = 4'd0;
        tick();
    endtask

    task automatic frame(input int kind, input logic [3:0] c1, input logic [3:0] c2);
        frame_body(kind, c1, c2);
        frame_close();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; col_idx = 2'd0; key_hit = 1'b0; key_code = 4'd0;
        repeat_en = 1'b0; clr_ovf = 1'b0; ev_if.ev_ready = 1'b0;
        tick(); tick();
        check("rst_valid", ev_if.ev_valid, 0);
        check("rst_type", ev_if.ev_type, 0);
        check("rst_code", ev_if.ev_code, 0);
        check("rst_held", held, 0);
        check("rst_held_code", held_code, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;

        // Idle scanning
        for (int i = 0; i < 10; i++) frame(0, 4'd0, 4'd0);
        check("idle_valid", ev_if.ev_valid, 0);
        check("idle_held", held, 0);
        check("idle_count", fifo_count, 0);

        // Press / release of key 5, consumer stalled to observe timing
        frame(1, 4'd5, 4'd0);
        check("pr_confirm_held", held, 0);
        frame_body(1, 4'd5, 4'd0);
        check("pr_pre_valid", ev_if.ev_valid, 0);
        frame_close();
        check("pr_valid", ev_if.ev_valid, 1);
        check("pr_type", ev_if.ev_type, 2'b01);
        check("pr_code", ev_if.ev_code, 5);
        check("pr_held", held, 1);
        check("pr_held_code", held_code, 5);
        check("pr_count1", fifo_count, 1);
        frame(1, 4'd5, 4'd0);
        check("pr_hold_count", fifo_count, 1);
        frame(0, 4'd0, 4'd0);
        check("pr_rel_count", fifo_count, 2);
        check("pr_rel_held", held, 0);
        check("pr_head_stable", {ev_if.ev_type, ev_if.ev_code}, 6'h15);
        ev_if.ev_ready = 1'b1;
        repeat (3) tick();
        check("pr_nq", evq.size(), 2);
        check("pr_ev0", ev_at(0), 6'h15);
        check("pr_ev1", ev_at(1), 6'h35);
        evq.delete();

        // Auto-repeat of key 0: PRESS at frame 2, REPEAT at 18, 22, 26
        repeat_en = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            frame(1, 4'd0, 4'd0);
            check($sformatf("rep_valid_f%0d", i), ev_if.ev_valid,
                  (i == 2 || i == 18 || i == 22 || i == 26));
            if (i == 18 || i == 22 || i == 26)
                check($sformatf("rep_type_f%0d", i), ev_if.ev_type, 2'b10);
        end
        frame(0, 4'd0, 4'd0);
        repeat (2) tick();
        check("rep_nq", evq.size(), 5);
        check("rep_ev0", ev_at(0), 6'h10);
        check("rep_ev1", ev_at(1), 6'h20);
        check("rep_ev2", ev_at(2), 6'h20);
        check("rep_ev3", ev_at(3), 6'h20);
        check("rep_ev4", ev_at(4), 6'h30);
        evq.delete();

        // Same hold length with auto-repeat disabled
        repeat_en = 1'b0;
        for (int i = 1; i <= 26; i++) frame(1, 4'd2, 4'd0);
        check("norep_held", held, 1);
        frame(0, 4'd0, 4'd0);
        repeat (2) tick();
        check("norep_nq", evq.size(), 2);
        check("norep_ev0", ev_at(0), 6'h12);
        check("norep_ev1", ev_at(1), 6'h32);
        evq.delete();

        // Ghosting tolerance and key change
        frame(1, 4'd3, 4'd0);
        frame(1, 4'd3, 4'd0);
        frame(2, 4'd3, 4'd7);
        check("gh_multi_held", held, 1);
        check("gh_multi_code", held_code, 3);
        frame(1, 4'd9, 4'd0);
        check("gh_change_held", held, 0);
        check("gh_change_code", held_code, 9);
        frame(1, 4'd9, 4'd0);
        check("gh_press9_held", held, 1);
        frame(0, 4'd0, 4'd0);
        repeat (2) tick();
        check("gh_nq", evq.size(), 4);
        check("gh_ev0", ev_at(0), 6'h13);
        check("gh_ev1", ev_at(1), 6'h33);
        check("gh_ev2", ev_at(2), 6'h19);
        check("gh_ev3", ev_at(3), 6'h39);
        evq.delete();

        // Backpressure: five events into a four-entry FIFO
        ev_if.ev_ready = 1'b0;
        frame(1, 4'd4, 4'd0); frame(1, 4'd4, 4'd0); frame(0, 4'd0, 4'd0);
        frame(1, 4'd6, 4'd0); frame(1, 4'd6, 4'd0); frame(0, 4'd0, 4'd0);
        check("ov_pre_ovf", overflow, 0);
        frame(1, 4'd8, 4'd0); frame(1, 4'd8, 4'd0);
        check("ov_count", fifo_count, 4);
        check("ov_flag", overflow, 1);
        check("ov_head", {ev_if.ev_type, ev_if.ev_code}, 6'h14);
        check("ov_held8", held, 1);
        ev_if.ev_ready = 1'b1;
        repeat (6) tick();
        check("ov_drained", fifo_count, 0);
        check("ov_nq", evq.size(), 4);
        check("ov_ev0", ev_at(0), 6'h14);
        check("ov_ev1", ev_at(1), 6'h34);
        check("ov_ev2", ev_at(2), 6'h16);
        check("ov_ev3", ev_at(3), 6'h36);
        check("ov_sticky", overflow, 1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ov_cleared", overflow, 0);
        frame(0, 4'd0, 4'd0);
        repeat (2) tick();
        check("ov_rel8", ev_at(4), 6'h38);
        evq.delete();

        // Reset while repeating with two events queued
        repeat_en = 1'b1;
        ev_if.ev_ready = 1'b0;
        for (int i = 1; i <= 18; i++) frame(1, 4'd1, 4'd0);
        check("mr_count", fifo_count, 2);
        check("mr_held", held, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mr_valid", ev_if.ev_valid, 0);
        check("mr_count0", fifo_count, 0);
        check("mr_held0", held, 0);
        check("mr_held_code0", held_code, 0);
        ev_if.ev_ready = 1'b1;
        frame(0, 4'd0, 4'd0); frame(0, 4'd0, 4'd0);
        repeat (2) tick();
        check("mr_no_release", evq.size(), 0);
        check("mr_valid_after", ev_if.ev_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
- Sits downstream of the 4x4 matrix scanner and turns its per-column key samples into discrete key events: PRESS, REPEAT and RELEASE.
- Groups samples into scan frames, one frame per full column sweep.
- Confirms a key over several frames, produces timed auto-repeat, and detects release.
- Buffers events in a small FIFO with a valid/ready interface for the consumer (UART or display logic).

Parameters:
- CONFIRM_FRAMES, 2: consecutive identical single-key frames required before PRESS. Legal range 2..255.
- REPEAT_DELAY, 16: held frames after PRESS before the first REPEAT. Legal range 1..255.
- REPEAT_RATE, 4: held frames between subsequent REPEATs. Legal range 1..255.
- FIFO_DEPTH, 4: event FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- col_idx  in  2  scanner active-column index
- key_hit  in  1  high when exactly one debounced row is active in the current column
- key_code  in  4  scanner key code; meaningful only when key_hit=1
- repeat_en  in  1  enables auto-repeat
- ev_ready  in  1  consumer accepts the event
- ev_valid  out  1  FIFO head is valid
- ev_type  out  2  event type: 01 PRESS, 10 REPEAT, 11 RELEASE
- ev_code  out  4  key code of the event
- held  out  1  high in HELD or REPEAT state
- held_code  out  4  code of the held key (cand)
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky flag: an event was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - FIFO is emptied; frame accumulator is cleared; prev_col is 3.
- Frame boundary:
  - frame_end is a one-cycle pulse when prev_col==3 and col_idx==0.
  - prev_col is registered every cycle.
- Frame accumulator:
  - A key_hit cycle with seen=0 latches code and sets seen=1.
  - A key_hit cycle with seen=1 and key_code != latched code sets multi=1.
- Frame result at frame_end, using the accumulator state from before this cycle:
  - NONE when seen=0.
  - MULTI when multi=1.
  - SINGLE(code) otherwise.
  - In the same cycle the accumulator reinitialises from the current sample, which belongs to the new frame.
- FSM, evaluated only on frame_end; cnt is 8 bits, saturating:
  - IDLE: SINGLE(c) -> cand=c, cnt=1, go CONFIRM. NONE or MULTI -> stay.
  - CONFIRM:
    - SINGLE(cand) -> cnt+1. If cnt+1==CONFIRM_FRAMES: push PRESS(cand), cnt=0, go HELD.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE -> IDLE.
    - MULTI -> no change.
  - HELD:
    - SINGLE(cand) -> cnt+1. If repeat_en and cnt+1==REPEAT_DELAY: push REPEAT(cand), cnt=0, go REPEAT.
    - NONE -> push RELEASE(cand), go IDLE.
    - SINGLE(other) -> push RELEASE(old cand), cand=other, cnt=1, go CONFIRM.
    - MULTI -> no change (ghosting tolerance).
  - REPEAT: as HELD, but the threshold is REPEAT_RATE, the next state is REPEAT, and the repeat_en=0 rule below applies.
  - repeat_en=0 in REPEAT -> go HELD with cnt=0. No REPEAT is pushed while repeat_en=0.
- FIFO:
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set. Overflow clears on reset or clr_ovf; a set in the same cycle as clr_ovf wins.
  - Pop when ev_valid && ev_ready. ev_type/ev_code present the FIFO head and stay stable while ev_valid=1 and ev_ready=0.
  - Push into an empty FIFO: ev_valid rises the cycle after frame_end. Push and pop never bypass combinationally.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is +1 on push, -1 on pop, unchanged on push+pop.
- Release still fires after a dropped PRESS; the FSM never depends on FIFO state.

Test Plan:
- Idle scan: no key_hit for 10 frames -> ev_valid stays 0, held=0, fifo_count=0.
- Press/release, default parameters: key 5 SINGLE for 3 frames, then NONE.
  - Second frame_end pushes PRESS(5) (ev_type=01, ev_code=5).
  - ev_valid rises the next cycle; held=1, held_code=5.
  - The NONE frame pushes RELEASE(5) (11); held drops.
- Auto-repeat: repeat_en=1, key 0 held 2+16+8 frames with ev_ready=1 -> sequence PRESS(0), REPEAT(0), REPEAT(0), REPEAT(0).
  - The first REPEAT occurs 16 frames after PRESS; subsequent ones every 4 frames.
  - A repeat_en=0 run of the same length gives PRESS only.
- Key change and ghosting:
  - A held 3 is followed by a MULTI frame -> no event, state unchanged.
  - Then SINGLE(9) -> RELEASE(3) pushed; 9 enters CONFIRM; the next SINGLE(9) frame -> PRESS(9).
- Backpressure/overflow: ev_ready=0, FIFO_DEPTH=4, generate 5 events -> fifo_count=4, overflow=1, the 5th event is lost.
  - Raise ev_ready -> the 4 original events drain in order.
  - clr_ovf pulse -> overflow=0.
- Mid-operation reset: assert reset in REPEAT with 2 queued events -> next cycle ev_valid=0, fifo_count=0, held=0, state IDLE, no RELEASE emitted.
